md_unit: RTL and testbench

//  Multi-cycle multiply/divide unit beside the ALU in the EX stage of the pipelined CPU.

---
 rtl/md_defs.sv | 26 ++
 rtl/md_arith.sv | 63 ++++++
 rtl/md_unit.sv | 112 +++++++++++
 tb/tb_md_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit: md_op encodings, FSM states
// and a decode helper used by both the datapath and the sequencer.
package md_defs;

  typedef enum logic [3:0] {
    MD_MULT  = 4'b0000,
    MD_MULTU = 4'b0001,
    MD_DIV   = 4'b0010,
    MD_DIVU  = 4'b0011,
    MD_MFHI  = 4'b0100,
    MD_MFLO  = 4'b0101,
    MD_MTHI  = 4'b0110,
    MD_MTLO  = 4'b0111
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the four ops that occupy the unit for a full latency period.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: produces the HI/LO result for the
// selected op, and res_we=0 when HI/LO must stay unchanged (divide by zero).
module md_arith
  import md_defs::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_we
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic [31:0] w_num;
  logic [31:0] w_den;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_prod_s = {{32{A1[31]}}, A1} * {{32{A2[31]}}, A2};
  assign w_prod_u = {32'b0, A1} * {32'b0, A2};

  // One unsigned divider serves both DIV and DIVU; signed division works on
  // magnitudes. 0x80000000 / -1 falls out as q=0x80000000, r=0 this way.
  assign w_signed_div = (md_op == MD_DIV);
  assign w_num = (w_signed_div && A1[31]) ? (~A1 + 32'd1) : A1;
  assign w_den = (A2 == 32'd0) ? 32'd1 :
                 ((w_signed_div && A2[31]) ? (~A2 + 32'd1) : A2);
  assign w_q   = w_num / w_den;
  assign w_r   = w_num % w_den;

  // NOTE: every output gets a default before the case so no path can leave
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_we = 1'b0;
    case (md_op)
      MD_MULT: begin
        {res_hi, res_lo} = w_prod_s;
        res_we = 1'b1;
      end
      MD_MULTU: begin
        {res_hi, res_lo} = w_prod_u;
        res_we = 1'b1;
      end
      MD_DIV: begin
        res_lo = (A1[31] ^ A2[31]) ? (~w_q + 32'd1) : w_q;
        res_hi = A1[31] ? (~w_r + 32'd1) : w_r;
        res_we = (A2 != 32'd0);
      end
      MD_DIVU: begin
        res_lo = w_q;
        res_hi = w_r;
        res_we = (A2 != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: latches the result into shadow registers at
// start, counts down the op latency, then commits to HI/LO.
module md_unit
  import md_defs::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  input  logic        md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_e        r_state;
  md_state_e        w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_shadow_hi;
  logic [31:0]      r_shadow_lo;
  logic             r_shadow_we;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_res_we;
  logic             w_start_arith;
  logic             w_idle_start;
  logic             w_commit;

  md_arith u_arith (
    .md_op  (md_op),
    .A1     (A1),
    .A2     (A2),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo),
    .res_we (w_res_we)
  );

  assign w_start_arith = start && is_arith(md_op);
  assign w_idle_start  = start && (r_state == ST_IDLE);
  assign w_commit      = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start_arith) w_next_state = ST_RUN;
      ST_RUN:  if (r_cnt == CNT_W'(1)) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shadow_hi <= '0;
      r_shadow_lo <= '0;
      r_shadow_we <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_start_arith) begin
        r_cnt       <= ((md_op == MD_DIV) || (md_op == MD_DIVU)) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        r_shadow_hi <= w_res_hi;
        r_shadow_lo <= w_res_lo;
        r_shadow_we <= w_res_we;
      end
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Commit only happens in RUN, moves only in IDLE, so the two never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (w_commit) begin
      if (r_shadow_we) begin
        hi <= r_shadow_hi;
        lo <= r_shadow_lo;
      end
    end else if (w_idle_start && (md_op == MD_MTHI)) begin
      hi <= A1;
    end else if (w_idle_start && (md_op == MD_MTLO)) begin
      lo <= A1;
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign md_stall = md_use && (busy || w_start_arith);

  always_comb begin
    md_out = 32'd0;
    if (md_op == MD_MFHI)      md_out = hi;
    else if (md_op == MD_MFLO) md_out = lo;
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a cycle-indexed reference model checked on
// every falling edge, plus directed vectors with hand-computed results.
module tb_md_unit;
  import md_defs::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam logic [3:0] NOP = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  md_op = NOP;
  logic [31:0] A1 = '0;
  logic [31:0] A2 = '0;
  logic        md_use = 1'b0;
  logic        busy, md_stall;
  logic [31:0] md_out, hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  md_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .A1(A1), .A2(A2),
    .md_use(md_use), .busy(busy), .md_stall(md_stall), .md_out(md_out),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from 64-bit arithmetic: {we, hi, lo}.
  function automatic logic [64:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      4'd0: begin r = 64'(sa * sb); return {1'b1, r}; end
      4'd1: begin r = ua * ub;      return {1'b1, r}; end
      4'd2: if (b == 0) return 65'd0;
            else return {1'b1, 32'(sa % sb), 32'(sa / sb)};
      4'd3: if (b == 0) return 65'd0;
            else return {1'b1, 32'(ua % ub), 32'(ua / ub)};
      default: return 65'd0;
    endcase
  endfunction

  // Model: edge index of the pending commit and the values it will write.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_run, p_we;
  int          m_cyc, m_commit_at;

  always @(posedge clk or negedge rst_n) begin
    logic [64:0] r;
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_run <= 1'b0; m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_run) begin
        if (m_cyc == m_commit_at) begin
          m_run <= 1'b0;
          if (p_we) begin m_hi <= p_hi; m_lo <= p_lo; end
        end
      end else if (start) begin
        if (md_op <= 4'd3) begin
          r = model_res(md_op, A1, A2);
          p_we <= r[64]; p_hi <= r[63:32]; p_lo <= r[31:0];
          m_run <= 1'b1;
          m_commit_at <= m_cyc + ((md_op >= 4'd2) ? DIV_LAT : MUL_LAT);
        end else if (md_op == 4'd6) m_hi <= A1;
        else if (md_op == 4'd7) m_lo <= A1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'b0, busy}, {31'b0, m_run});
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
      check("cyc_stall", {31'b0, md_stall}, {31'b0, md_use & (m_run | (start & (md_op <= 4'd3)))});
      check("cyc_md_out", md_out, (md_op == 4'd4) ? m_hi : ((md_op == 4'd5) ? m_lo : 32'd0));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; A1 = a; A2 = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = NOP;
  endtask

  // Counts busy cycles until idle; bounded so a stuck unit shows as a bad count.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
  endtask

  int nb, ns;

  initial begin
    #3 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(nb);
    check("mult_busy_len", nb, MUL_LAT);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(nb);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(nb);
    check("div_busy_len", nb, DIV_LAT);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle(nb);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    issue(MD_MTHI, 32'h11, 32'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    issue(MD_DIV, 32'd1234, 32'd0);
    wait_idle(nb);
    check("div0_busy_len", nb, DIV_LAT);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    // Stall: start cycle plus every busy cycle, then released.
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_MULT; A1 = 32'd3; A2 = 32'd4; md_use = 1'b1;
    ns = 0;
    @(negedge clk); ns += int'(md_stall);
    @(posedge clk); #1;
    start = 1'b0; md_op = NOP;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); ns += int'(md_stall);
    end
    check("stall_len", ns, MUL_LAT + 1);
    md_use = 1'b0; md_op = MD_MFLO;
    #1 check("mflo_out", md_out, 32'd12);
    md_op = MD_MFHI;
    #1 check("mfhi_out", md_out, 32'd0);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(nb);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    issue(4'b1010, 32'hDEAD_BEEF, 32'd5);
    @(negedge clk);
    check("undef_busy", {31'b0, busy}, 32'd0);
    check("undef_lo", lo, 32'h8000_0000);

    issue(MD_DIV, 32'd100, 32'd7);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue(MD_MTLO, 32'h5A, 32'd0);
    @(negedge clk);
    check("mtlo_lo", lo, 32'h5A);
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
